// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 2*nb-bit dividend / nb-bit divisor using radix-2
// restoring division on magnitudes, with a start/ready handshake.
module seq_signed_divider #(
    parameter int nb = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*nb-1:0] A,
    input  logic [nb-1:0]   B,
    output logic [nb-1:0]   Quotient,
    output logic [nb-1:0]   Remainder,
    output logic            ready,
    output logic            div_zero,
    output logic            overflow
);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    localparam logic [nb-1:0] CNT_LAST = nb[nb-1:0] - 1'b1;

    state_t          state;
    state_t          state_next;
    logic [2*nb-1:0] a_reg;
    logic [2*nb-1:0] a_abs;
    logic [nb-1:0]   b_reg;
    logic [nb-1:0]   b_abs;
    logic [nb-1:0]   b_mag;
    logic [nb-1:0]   rem_r;
    logic [nb-1:0]   dvd_lo;
    logic [nb-1:0]   q_r;
    logic [nb-1:0]   cnt;
    logic [nb-1:0]   rem_next;
    logic [nb:0]     trial;
    logic [nb:0]     diff;
    logic            sa;
    logic            sb;
    logic            early;
    logic            ge;
    logic            zero_div;
    logic            early_ovf;
    logic            qs;
    logic            late_ovf;

    // The partial remainder stays below |B|, so bit nb of the difference is the borrow.
    always_comb begin
        a_abs     = a_reg[2*nb-1] ? -a_reg : a_reg;
        b_abs     = b_reg[nb-1] ? -b_reg : b_reg;
        zero_div  = (b_reg == '0);
        early_ovf = (a_abs[2*nb-1:nb] >= b_abs);
        trial     = {rem_r, dvd_lo[nb-1]};
        diff      = trial - {1'b0, b_mag};
        ge        = ~diff[nb];
        rem_next  = ge ? diff[nb-1:0] : trial[nb-1:0];
        qs        = sa ^ sb;
        late_ovf  = qs ? (q_r[nb-1] && (q_r[nb-2:0] != '0)) : q_r[nb-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE, DONE: ready = 1'b1;
            PREP:       state_next = (zero_div || early_ovf) ? FIX : RUN;
            RUN:        if (cnt == CNT_LAST) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
        if (start) begin
            state_next = PREP;
        end
    end

    // Early exits publish results in PREP and then pass through FIX untouched,
    // so every result becomes visible one edge after it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            b_mag     <= '0;
            rem_r     <= '0;
            dvd_lo    <= '0;
            q_r       <= '0;
            cnt       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            early     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (start) begin
            a_reg    <= A;
            b_reg    <= B;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                PREP: begin
                    sa     <= a_reg[2*nb-1];
                    sb     <= b_reg[nb-1];
                    b_mag  <= b_abs;
                    rem_r  <= a_abs[2*nb-1:nb];
                    dvd_lo <= a_abs[nb-1:0];
                    q_r    <= '0;
                    cnt    <= '0;
                    early  <= zero_div || early_ovf;
                    if (zero_div) begin
                        div_zero  <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= a_reg[nb-1:0];
                    end else if (early_ovf) begin
                        overflow  <= 1'b1;
                        Quotient  <= '0;
                        Remainder <= '0;
                    end
                end
                RUN: begin
                    rem_r  <= rem_next;
                    dvd_lo <= {dvd_lo[nb-2:0], 1'b0};
                    q_r    <= {q_r[nb-2:0], ge};
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    if (!early) begin
                        if (late_ovf) begin
                            overflow  <= 1'b1;
                            Quotient  <= '0;
                            Remainder <= '0;
                        end else begin
                            Quotient  <= qs ? -q_r : q_r;
                            Remainder <= sa ? -rem_r : rem_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomized scoreboard bench for seq_signed_divider (nb=32) against an
// arithmetic reference model of truncating signed division.
module tb_seq_signed_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        ready;
    logic        div_zero;
    logic        overflow;

    exp_t sb_q[$];
    int   cyc = 0;
    int   start_cyc = 0;
    int   checkCount = 0;
    int   passCount = 0;
    bit   abort_pending = 1'b0;
    logic prev_ready = 1'b1;

    seq_signed_divider #(.nb(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .A(A),
        .B(B),
        .Quotient(Quotient),
        .Remainder(Remainder),
        .ready(ready),
        .div_zero(div_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Truncating division on wide signed integers; early-exit timing follows |q| >= 2^32.
    function automatic exp_t model(input logic signed [63:0] a, input logic signed [31:0] b);
        exp_t e;
        logic signed [65:0] aw, bw, q, r, absa, absb;
        aw = a;
        bw = b;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.q   = '0;
            e.r   = a[31:0];
            e.lat = 2;
        end else begin
            q = aw / bw;
            r = aw % bw;
            absa = (aw < 0) ? -aw : aw;
            absb = (bw < 0) ? -bw : bw;
            e.lat = (absa >= (absb <<< 32)) ? 2 : 34;
            if (q > 66'sd2147483647 || q < -66'sd2147483648) begin
                e.ov = 1'b1;
                e.q  = '0;
                e.r  = '0;
            end else begin
                e.q = q[31:0];
                e.r = r[31:0];
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [63:0] a, input logic [31:0] b, input bit push);
        if (push) sb_q.push_back(model(a, b));
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising edge of ready completes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (ready === 1'b1 && prev_ready === 1'b0) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
                checkOutput("abort_q", Quotient, 0);
                checkOutput("abort_r", Remainder, 0);
                checkOutput("abort_flags", {div_zero, overflow}, 0);
            end else if (sb_q.size() == 0) begin
                checkOutput("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("quotient", Quotient, e.q);
                checkOutput("remainder", Remainder, e.r);
                checkOutput("div_zero", div_zero, e.dz);
                checkOutput("overflow", overflow, e.ov);
                checkOutput("latency", cyc - start_cyc, e.lat);
            end
        end
        prev_ready = ready;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [63:0] a;
        logic signed [31:0] b;
        logic signed [63:0] corner_a[4];
        logic signed [31:0] corner_b[4];
        corner_a = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        corner_b = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_q", Quotient, 0);
        checkOutput("reset_r", Remainder, 0);
        checkOutput("reset_flags", {div_zero, overflow}, 0);
        @(posedge clk);
        #1;

        applyStimulus(64'sd100, 32'sd7, 1); waitDone();
        applyStimulus(-64'sd100, 32'sd7, 1); waitDone();
        applyStimulus(64'sd100, -32'sd7, 1); waitDone();
        applyStimulus(-64'sd100, -32'sd7, 1); waitDone();
        applyStimulus(-64'sd123456 * 64'sd98765, 32'sd98765, 1); waitDone();
        applyStimulus(64'sd2147483648, 32'sd1, 1); waitDone();
        applyStimulus(-64'sd2147483648, 32'sd1, 1); waitDone();
        applyStimulus(64'sd1 <<< 40, 32'sd2, 1); waitDone();
        applyStimulus(64'sd5, 32'sd0, 1); waitDone();
        applyStimulus(64'sd0, 32'sd5, 1); waitDone();
        applyStimulus(64'h8000_0000_0000_0000, 32'h8000_0000, 1); waitDone();
        applyStimulus(-(64'sd1 <<< 62), 32'h8000_0000, 1); waitDone();
        applyStimulus(64'sd1 <<< 62, 32'h8000_0000, 1); waitDone();

        // Restart mid-RUN: only the second operation may complete.
        applyStimulus(64'sd1000, 32'sd3, 0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(64'sd9, 32'sd3, 1);
        waitDone();

        // Start held for several cycles: result timed from the last start edge.
        sb_q.push_back(model(-64'sd77, 32'sd5));
        A = -64'sd77;
        B = 32'sd5;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        waitDone();

        // Reset in the middle of an operation aborts it.
        applyStimulus(64'sd1000, 32'sd3, 0);
        repeat (9) @(posedge clk);
        #1;
        abort_pending = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        if (abort_pending) begin
            checkOutput("abort_seen", 0, 1);
            abort_pending = 1'b0;
        end

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = {$urandom, $urandom};
                    b = $urandom;
                end
                1: begin
                    b = $urandom;
                    a = longint'($signed($urandom)) * longint'(b) + longint'($urandom_range(0, 5));
                end
                2: begin
                    a = longint'($signed($urandom));
                    b = $urandom_range(1, 1000);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: begin
                    a = corner_a[$urandom_range(0, 3)];
                    b = ($urandom_range(0, 4) == 4) ? $urandom : corner_b[$urandom_range(0, 3)];
                    if ($urandom_range(0, 1) == 1) a = a >>> $urandom_range(1, 40);
                end
            endcase
            applyStimulus(a, b, 1);
            waitDone();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
